// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multi-cycle multiply/divide units and HI/LO writeback
//
// Build option: define MULDIV_DIVZERO_EN to build divide-by-zero detection
// (the DIVZ state and the div_zero_exc_o pulse). Without it, a zero divisor
// runs the normal divide sequence and div_zero_exc_o is tied low.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   op_mult_i      one-cycle multiply request
//   op_div_i       one-cycle divide request
//   divisor_i      B operand, checked for zero when a divide is accepted
//   mult_start_o   one-cycle start pulse to the multiply unit
//   div_start_o    one-cycle start pulse to the divide unit
//   hi_lo_src_o    HI/LO input select: 0 = divide results, 1 = multiply results
//   hi_write_o     HI register write enable
//   lo_write_o     LO register write enable
//   busy_o         operation in progress (main control stalls)
//   done_o         one-cycle pulse once HI/LO hold the new result
//   div_zero_exc_o one-cycle pulse on a divide request with a zero divisor
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        op_mult_i,
    input  logic        op_div_i,
    input  logic [31:0] divisor_i,
    output logic        mult_start_o,
    output logic        div_start_o,
    output logic        hi_lo_src_o,
    output logic        hi_write_o,
    output logic        lo_write_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_exc_o
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        WB,
`ifdef MULDIV_DIVZERO_EN
        DONE,
        DIVZ
`else
        DONE
`endif
    } state_t;

    // RUN lasts N cycles, so the counter is loaded with N-1 and exits at 0
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mult_start_q;
    logic             div_start_q;
    logic             hi_lo_src_q;
    logic             wr_q;
    logic             busy_q;
    logic             done_q;
    logic             div_go;

`ifdef MULDIV_DIVZERO_EN
    logic dz_q;
    assign div_go         = op_div_i && (divisor_i != '0);
    assign div_zero_exc_o = dz_q;
`else
    logic unused_divisor;
    assign unused_divisor = ^divisor_i;
    assign div_go         = op_div_i;
    assign div_zero_exc_o = 1'b0;
`endif

    // Start pulses and busy are set on the accepting edge so they appear in
    // the cycle right after the request without any combinational path.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            hi_lo_src_q  <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            dz_q         <= 1'b0;
`endif
        end else begin
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            wr_q         <= 1'b0;
            done_q       <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            dz_q         <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (op_mult_i) begin
                        state_q      <= START;
                        hi_lo_src_q  <= 1'b1;
                        cnt_q        <= MULT_LOAD;
                        mult_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (div_go) begin
                        state_q      <= START;
                        hi_lo_src_q  <= 1'b0;
                        cnt_q        <= DIV_LOAD;
                        div_start_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
`ifdef MULDIV_DIVZERO_EN
                    else if (op_div_i) begin
                        state_q <= DIVZ;
                        dz_q    <= 1'b1;
                    end
`endif
                end
                START: state_q <= RUN;
                RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= WB;
                        wr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WB: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mult_start_o = mult_start_q;
    assign div_start_o  = div_start_q;
    assign hi_lo_src_o  = hi_lo_src_q;
    assign hi_write_o   = wr_q;
    assign lo_write_o   = wr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule
